// File: rtl/neuron_mac_q69.sv
// Q6.9 dot-product MAC feeding tanhPWL.
// Rounds and clamps the sum to [-8,+8) and emits x/x_valid/y_valid.
module neuron_mac_q69 #(
  parameter int VEC_LEN = 16,
  parameter int FRAC    = 9,
  parameter int ACC_W   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_w,
  input  logic [15:0] bias,
  input  logic        clear,
  output logic [15:0] x,
  output logic        x_valid,
  output logic        sat,
  output logic        y_valid
);

  localparam int CNT_W = (VEC_LEN < 2) ? 1 : $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] X_MAX = ACC_W'(4095);
  localparam logic signed [ACC_W-1:0] X_MIN = ACC_W'(-4096);

  logic [1:0]              state, state_d;
  logic signed [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0]        cnt, cnt_d;

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_rnd;
  logic signed [ACC_W-1:0] r;
  logic [15:0]             x_d;
  logic                    sat_d;
  logic                    beat;

  assign in_ready = (state != S_ROUND);
  assign beat     = in_valid & in_ready;

  assign prod     = $signed(in_a) * $signed(in_w);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bias)) <<< FRAC;

  // Round half up: add half an LSB, then arithmetic shift.
  assign acc_rnd  = acc + RND_C;
  assign r        = acc_rnd >>> FRAC;

  always_comb begin
    x_d   = r[15:0];
    sat_d = 1'b0;
    if (r > X_MAX) begin
      x_d   = 16'h0FFF;
      sat_d = 1'b1;
    end else if (r < X_MIN) begin
      x_d   = 16'hF000;
      sat_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (beat) begin
          acc_d   = bias_ext + prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = (VEC_LEN == 1) ? S_ROUND : S_ACC;
        end
      end
      S_ACC: begin
        if (clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (beat) begin
          acc_d = acc + prod_ext;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      sat     <= 1'b0;
      x_valid <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      x_valid <= (state == S_ROUND);
      y_valid <= x_valid;
      if (state == S_ROUND) begin
        x   <= x_d;
        sat <= sat_d;
      end
    end
  end

endmodule

// File: doc/neuron_mac_q69.md
Name: neuron_mac_q69

Overview:
- Upstream feeder for the tanhPWL activation stage.
- Accumulates a VEC_LEN-element dot product of signed Q6.9 activations and weights, plus a Q6.9 bias.
- Rounds and clamps the result to the activation's valid input range [-8.0, +8.0), then presents it on the 16-bit x bus that tanhPWL registers.
- Generates x_valid, plus y_valid delayed to match tanhPWL's one-cycle latency, so the consumer knows when y is meaningful.

Parameters:
- VEC_LEN, 16: elements per dot product (≥1).
- FRAC, 9: fractional bits of all 16-bit operands (Q6.9; 0x0200 = 1.0).
- ACC_W, 40: accumulator width (signed); must be ≥ 32 + clog2(VEC_LEN) + 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  16  signed Q6.9 activation.
- in_w  in  16  signed Q6.9 weight.
- bias  in  16  signed Q6.9 bias; sampled with the first beat of each vector.
- clear  in  1  synchronous abort of the current vector.
- x  out  16  signed Q6.9 clamped pre-activation; connects to tanhPWL.x.
- x_valid  out  1  one-cycle pulse when x updates.
- sat  out  1  the result was clamped; valid with x_valid, held with x.
- y_valid  out  1  x_valid delayed 1 cycle; marks tanhPWL.y valid.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0 and after release:
  - state=IDLE, acc=0, count=0
  - x=0, x_valid=0, sat=0, y_valid=0
  - in_ready=1
- Reset mid-vector discards the partial sum with no output.
- States:
  - IDLE (in_ready=1): an accepted beat (in_valid&in_ready) sets acc = sext(bias)<<FRAC + a*w and count=1. Next state is ACC, or ROUND if VEC_LEN=1.
  - ACC (in_ready=1): an accepted beat does acc += a*w and count++. When count reaches VEC_LEN-1 and a beat is accepted, next state is ROUND. No beat means hold; gaps in in_valid are legal.
  - ROUND (in_ready=0): one cycle. Registers x and sat, pulses x_valid, then returns to IDLE.
- Arithmetic:
  - Product: full-precision signed 32-bit (Q12.18), sign-extended to ACC_W. No intermediate saturation.
  - Rounding: r = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round-half-up (toward +inf).
  - Clamp: r > 4095 gives x=0x0FFF, sat=1; r < -4096 gives x=0xF000, sat=1; otherwise x=r[15:0], sat=0.
- Latency and outputs:
  - x_valid rises on the clock edge after the final beat is accepted, and lasts exactly 1 cycle.
  - y_valid = x_valid delayed 1 cycle.
  - x and sat hold their values until the next ROUND.
- Back-to-back vectors: the first beat of the next vector is accepted in the cycle after ROUND (IDLE). Maximum throughput is VEC_LEN+1 cycles per result.
- clear:
  - In IDLE or ACC: returns to IDLE with count=0, acc cleared, no x_valid. The beat presented in the same cycle is consumed and discarded.
  - In ROUND: ignored; the result completes.
- in_valid while in_ready=0: the beat is not consumed; the source must hold it.
- No output backpressure: the consumer must accept every x_valid/y_valid pulse.

Test Plan:
- VEC_LEN=4, bias=0, 4× (a=0x0200, w=0x0100) → x=0x0400 (2.0), sat=0; x_valid 1 cycle after the 4th beat; y_valid the next cycle; tanhPWL.y sampled then.
- Saturation: 4× (a=0x7FFF, w=0x7FFF) → x=0x0FFF, sat=1. 4× (a=0x7FFF, w=0x8000) → x=0xF000, sat=1.
- Rounding: bias=0, beats (a=0x0001, w=0x0100) then 3× (0,0) → x=0x0001. Beats (a=0xFFFF, w=0x0100) then 3× (0,0) → x=0x0000 (half rounds up).
- Bias plus gaps: bias=0xFE00 (-1.0), 4× (0x0200, 0x0200) with in_valid low 2 cycles between beats → x=0x0600 (3.0); x_valid timing tracks the last accepted beat.
- Abort/reset: clear after 2 beats → no x_valid; the following full vector yields the correct result. rst_n low mid-vector → all outputs 0 asynchronously; a new vector after release is correct.
- Back-to-back: two vectors with in_valid held high; in_ready=0 only in the ROUND cycle; two x_valid pulses 5 cycles apart; each y_valid follows its x_valid by 1 cycle.
